// File: rtl/jtkcpu_memctl.sv
// Byte-wide external bus controller for the CPU: runs one 8-bit or big-endian 16-bit
// access per request, inserting wait states while bus_ok is low.
module jtkcpu_memctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        req,
    input  logic        wrq,
    input  logic        mem16,
    input  logic [15:0] addr,
    input  logic [15:0] din16,
    input  logic        halt,
    input  logic [7:0]  bus_din,
    input  logic        bus_ok,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout16,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_cs,
    output logic        bus_we,
    output logic        halt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [15:0] dout_q,     dout_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic        bus_cs_q,   bus_cs_d;
    logic        bus_we_q,   bus_we_d;
    logic        mem16_q,    mem16_d;
    logic [7:0]  din_lo_q,   din_lo_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dout_q     <= 16'h0000;
            bus_addr_q <= 16'h0000;
            bus_dout_q <= 8'h00;
            bus_cs_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            mem16_q    <= 1'b0;
            din_lo_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            bus_addr_q <= bus_addr_d;
            bus_dout_q <= bus_dout_d;
            bus_cs_q   <= bus_cs_d;
            bus_we_q   <= bus_we_d;
            mem16_q    <= mem16_d;
            din_lo_q   <= din_lo_d;
        end
    end

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        dout_d     = dout_q;
        bus_addr_d = bus_addr_q;
        bus_dout_d = bus_dout_q;
        bus_cs_d   = bus_cs_q;
        bus_we_d   = bus_we_q;
        mem16_d    = mem16_q;
        din_lo_d   = din_lo_q;

        if (cen) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req && !halt) begin
                        state_d    = ST_ACC1;
                        busy_d     = 1'b1;
                        bus_cs_d   = 1'b1;
                        bus_we_d   = wrq;
                        mem16_d    = mem16;
                        din_lo_d   = din16[7:0];
                        bus_addr_d = addr;
                        // Big-endian: a 16-bit access puts the high byte out first.
                        bus_dout_d = mem16 ? din16[15:8] : din16[7:0];
                    end
                end
                ST_ACC1: begin
                    if (bus_ok) begin
                        if (!bus_we_q) begin
                            if (mem16_q) dout_d[15:8] = bus_din;
                            else         dout_d       = {8'h00, bus_din};
                        end
                        if (mem16_q) begin
                            state_d    = ST_ACC2;
                            bus_addr_d = bus_addr_q + 16'd1;
                            bus_dout_d = din_lo_q;
                        end else begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            bus_cs_d = 1'b0;
                            bus_we_d = 1'b0;
                            done_d   = 1'b1;
                        end
                    end
                end
                ST_ACC2: begin
                    if (bus_ok) begin
                        if (!bus_we_q) dout_d[7:0] = bus_din;
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                        bus_cs_d = 1'b0;
                        bus_we_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    bus_cs_d = 1'b0;
                    bus_we_d = 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dout16   = dout_q;
    assign bus_addr = bus_addr_q;
    assign bus_dout = bus_dout_q;
    assign bus_cs   = bus_cs_q;
    assign bus_we   = bus_we_q;
    assign halt_ack = (state_q == ST_IDLE) && halt;

endmodule

// File: tb/tb_jtkcpu_memctl.sv
// Bench for jtkcpu_memctl: queue-of-bytes reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jtkcpu_memctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cen = 1'b0, req = 1'b0, wrq = 1'b0, mem16 = 1'b0, halt = 1'b0, bus_ok = 1'b0;
    logic [15:0] addr = 16'h0000, din16 = 16'h0000;
    logic [7:0]  bus_din = 8'h00;
    logic        busy, done, bus_cs, bus_we, halt_ack;
    logic [15:0] dout16, bus_addr;
    logic [7:0]  bus_dout;

    jtkcpu_memctl dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .req(req), .wrq(wrq), .mem16(mem16),
        .addr(addr), .din16(din16), .halt(halt), .bus_din(bus_din), .bus_ok(bus_ok),
        .busy(busy), .done(done), .dout16(dout16), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_cs(bus_cs), .bus_we(bus_we), .halt_ack(halt_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: an accepted request becomes a queue of byte transfers;
    // the head byte is what the bus shows, and bus_ok on a cen edge retires it.
    typedef enum {K_HI, K_LO, K_BYTE} kind_e;
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        kind_e       kind;
    } bop_t;

    bop_t        ops[$];
    logic [15:0] m_dout = 16'h0000;
    logic [15:0] m_addr = 16'h0000;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bop_t b;
        if (!rst_n) begin
            ops.delete();
            m_dout = 16'h0000;
            m_addr = 16'h0000;
            m_done = 1'b0;
        end else if (cen) begin
            m_done = 1'b0;
            if (ops.size() == 0) begin
                if (req && !halt) begin
                    if (mem16) begin
                        ops.push_back('{addr, din16[15:8], wrq, K_HI});
                        ops.push_back('{addr + 16'd1, din16[7:0], wrq, K_LO});
                    end else begin
                        ops.push_back('{addr, din16[7:0], wrq, K_BYTE});
                    end
                end
            end else if (bus_ok) begin
                b = ops.pop_front();
                if (!b.we) begin
                    case (b.kind)
                        K_HI:    m_dout[15:8] = bus_din;
                        K_LO:    m_dout[7:0]  = bus_din;
                        default: m_dout       = {8'h00, bus_din};
                    endcase
                end
                if (ops.size() == 0) m_done = 1'b1;
            end
            if (ops.size() != 0) m_addr = ops[0].a;
        end
    end

    always @(negedge clk) begin
        logic ne;
        if (cmp_en) begin
            ne = (ops.size() != 0);
            check("m_busy",     busy,     ne);
            check("m_bus_cs",   bus_cs,   ne);
            check("m_bus_we",   bus_we,   ne && ops[0].we);
            check("m_bus_addr", bus_addr, m_addr);
            check("m_dout16",   dout16,   m_dout);
            check("m_done",     done,     m_done);
            check("m_halt_ack", halt_ack, !ne && halt);
            if (ne && ops[0].we) check("m_bus_dout", bus_dout, ops[0].d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout16", dout16, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_dout", bus_dout, 0);
        check("rst_bus_cs", bus_cs, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_halt_ack", halt_ack, 0);
        tick();
        tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cen = 1'b1;

        // 16-bit read at 0x1234
        req = 1; wrq = 0; mem16 = 1; addr = 16'h1234; bus_ok = 1; bus_din = 8'hAB;
        tick();
        check("r16_busy", busy, 1);
        check("r16_addr1", bus_addr, 16'h1234);
        check("r16_cs", bus_cs, 1);
        check("r16_we", bus_we, 0);
        check("r16_done_e1", done, 0);
        req = 0;
        tick();
        check("r16_addr2", bus_addr, 16'h1235);
        check("r16_hi", dout16, 16'hAB00);
        check("r16_done_e2", done, 0);
        bus_din = 8'hCD;
        tick();
        check("r16_done_e3", done, 1);
        check("r16_dout", dout16, 16'hABCD);
        check("r16_idle", busy, 0);
        tick();
        check("r16_done_clr", done, 0);

        // 8-bit write with two wait states
        req = 1; wrq = 1; mem16 = 0; addr = 16'h8000; din16 = 16'h5A77; bus_ok = 0;
        tick();
        req = 0;
        for (int i = 0; i < 3; i++) begin
            check("w8_we", bus_we, 1);
            check("w8_dout", bus_dout, 8'h77);
            check("w8_addr", bus_addr, 16'h8000);
            check("w8_done_early", done, 0);
            if (i == 2) bus_ok = 1;
            tick();
        end
        check("w8_done", done, 1);
        check("w8_dout16_kept", dout16, 16'hABCD);
        check("w8_cs_off", bus_cs, 0);

        // 16-bit write at 0xFFFF wrapping, then back-to-back 8-bit read
        req = 1; wrq = 1; mem16 = 1; addr = 16'hFFFF; din16 = 16'h1122; bus_ok = 1;
        tick();
        check("w16_addr1", bus_addr, 16'hFFFF);
        check("w16_byte1", bus_dout, 8'h11);
        tick();
        check("w16_addr2", bus_addr, 16'h0000);
        check("w16_byte2", bus_dout, 8'h22);
        check("w16_we2", bus_we, 1);
        addr = 16'h0100; mem16 = 0; wrq = 0; bus_din = 8'h5E;
        tick();
        check("w16_done", done, 1);
        check("w16_dout16_kept", dout16, 16'hABCD);
        tick();
        check("b2b_busy", busy, 1);
        check("b2b_done_clr", done, 0);
        check("b2b_addr", bus_addr, 16'h0100);
        req = 0;
        tick();
        check("b2b_done", done, 1);
        check("b2b_dout", dout16, 16'h005E);

        // Reset dropped during ACC2
        req = 1; wrq = 0; mem16 = 1; addr = 16'h4000; bus_din = 8'hF0;
        tick();
        req = 0;
        tick();
        check("rac2_hi", dout16, 16'hF05E);
        bus_ok = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rac2_busy", busy, 0);
        check("rac2_dout16", dout16, 0);
        check("rac2_addr", bus_addr, 0);
        check("rac2_bus_dout", bus_dout, 0);
        check("rac2_cs", bus_cs, 0);
        check("rac2_we", bus_we, 0);
        check("rac2_done", done, 0);
        tick();
        rst_n = 1'b1; bus_ok = 1;
        tick();
        check("rac2_no_done", done, 0);
        req = 1; mem16 = 0; addr = 16'h0042; bus_din = 8'h99;
        tick();
        check("rac2_accept", busy, 1);
        req = 0;
        tick();
        check("rac2_next_done", done, 1);
        check("rac2_next_dout", dout16, 16'h0099);

        // halt during a 16-bit read
        req = 1; mem16 = 1; addr = 16'h2000; bus_din = 8'h12;
        tick();
        halt = 1;
        #1 check("halt_ack_busy", halt_ack, 0);
        tick();
        bus_din = 8'h34;
        tick();
        check("halt_done", done, 1);
        check("halt_dout", dout16, 16'h1234);
        check("halt_ack_on", halt_ack, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_ignored", busy, 0);
            check("halt_ack_held", halt_ack, 1);
        end
        mem16 = 0; bus_din = 8'h77; halt = 0;
        #1 check("halt_ack_drop", halt_ack, 0);
        tick();
        check("halt_release_accept", busy, 1);
        req = 0;
        tick();
        check("halt_release_done", done, 1);
        check("halt_release_dout", dout16, 16'h0077);

        // cen toggling during an 8-bit read
        req = 1; addr = 16'h3000; bus_din = 8'h66;
        tick();
        req = 0; cen = 0;
        tick();
        check("cen_busy_frozen", busy, 1);
        check("cen_no_done", done, 0);
        check("cen_dout_frozen", dout16, 16'h0077);
        cen = 1;
        tick();
        check("cen_done", done, 1);
        check("cen_dout", dout16, 16'h0066);
        cen = 0; bus_din = 8'h11;
        tick();
        check("cen_done_held1", done, 1);
        tick();
        check("cen_done_held2", done, 1);
        cen = 1;
        tick();
        check("cen_done_clr", done, 0);
        check("cen_dout_kept", dout16, 16'h0066);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cen     = ($urandom_range(0, 3) != 0);
            req     = ($urandom_range(0, 9) < 4);
            wrq     = $urandom_range(0, 1) == 1;
            mem16   = $urandom_range(0, 1) == 1;
            halt    = ($urandom_range(0, 9) == 0);
            bus_ok  = ($urandom_range(0, 9) < 7);
            addr    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            din16   = 16'($urandom);
            bus_din = 8'($urandom);
            rst_n   = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1; req = 0; cen = 1; bus_ok = 1;
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkcpu_memctl.md
JTKCPU_MEMCTL -- requirements
Module: jtkcpu_memctl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cen  input  1  clock enable; state advances only on edges where cen=1.
REQ-004 req  input  1  access request from CPU control; sampled only in IDLE.
REQ-005 wrq  input  1  1=write, 0=read; latched with req.
REQ-006 mem16  input  1  1=16-bit access (two bytes), 0=8-bit; latched with req.
REQ-007 addr  input  16  access address; latched with req.
REQ-008 din16  input  16  write data; latched with req; 8-bit writes use din16[7:0].
REQ-009 halt  input  1  blocks acceptance of new requests.
REQ-010 bus_din  input  8  external read data.
REQ-011 bus_ok  input  1  external ready; 0 inserts wait states.
REQ-012 busy  output  1  access in progress (mem_busy to control).
REQ-013 done  output  1  one-cen-cycle completion pulse.
REQ-014 dout16  output  16  read result.
REQ-015 bus_addr  output  16  external address.
REQ-016 bus_dout  output  8  external write data.
REQ-017 bus_cs  output  1  external chip select.
REQ-018 bus_we  output  1  external write strobe, valid only while bus_cs=1.
REQ-019 halt_ack  output  1  high while in IDLE and halt=1.

Function
REQ-020 FSM states SHALL be IDLE, ACC1 (first/only byte), ACC2 (second byte of 16-bit access).
REQ-021 IDLE->ACC1 on cen edge with req=1 and halt=0; addr, wrq, mem16, din16 latched on the same edge.
REQ-022 req while busy=1 or halt=1 SHALL be ignored, not queued.
REQ-023 busy SHALL be registered: 1 in ACC1/ACC2, 0 in IDLE.
REQ-024 bus_cs=1 in ACC1/ACC2, 0 in IDLE; bus_we = latched wrq while bus_cs=1, else 0.
REQ-025 ACC1: bus_addr = latched addr; ACC2: bus_addr = latched addr+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-026 Big-endian order: 16-bit write drives din16[15:8] in ACC1 and din16[7:0] in ACC2; 8-bit write drives din16[7:0] in ACC1.
REQ-027 A byte completes on a cen edge with bus_ok=1; with bus_ok=0 state, bus_addr, bus_dout and bus_cs SHALL hold.
REQ-028 ACC1 completion: mem16=1 -> ACC2; mem16=0 -> IDLE. ACC2 completion -> IDLE.
REQ-029 16-bit read: bus_din captured into dout16[15:8] at ACC1 completion and into dout16[7:0] at ACC2 completion.
REQ-030 8-bit read: dout16 = {8'h00, bus_din} at ACC1 completion.
REQ-031 Writes SHALL leave dout16 unchanged.
REQ-032 done SHALL be 1 for exactly one cen cycle, set on the final completion edge; done stays 1 while cen=0 and clears on the next cen edge.
REQ-033 Zero-wait latency (accept edge to done high): 8-bit = 2 cen edges, 16-bit = 3; each bus_ok=0 cycle adds one.
REQ-034 A new req MAY be accepted on the cen edge immediately after done rises (back-to-back).
REQ-035 halt asserted mid-access SHALL NOT abort it; the access finishes, then the block remains in IDLE with halt_ack=1.
REQ-036 cen=0 SHALL freeze all state and outputs regardless of req or bus_ok.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, dout16=0, bus_addr=0, bus_dout=0, bus_cs=0 and bus_we=0, including mid-access.
REQ-038 After rst_n release, the first request is accepted on the first cen edge with req=1 and halt=0.

Verification
REQ-039 16-bit read at 0x1234, bus_din 0xAB then 0xCD, bus_ok=1 -> bus_addr 0x1234 then 0x1235, dout16=0xABCD, done on 3rd cen edge.
REQ-040 8-bit write of din16=0x5A77 at 0x8000, bus_ok low for 2 cycles -> bus_we=1, bus_dout=0x77 held for 3 cycles, done on 4th edge, dout16 unchanged.
REQ-041 16-bit write at 0xFFFF, din16=0x1122 -> bytes 0x11 at 0xFFFF and 0x22 at 0x0000.
REQ-042 rst_n dropped during ACC2 -> all outputs zero immediately; no done pulse; next req completes normally.
REQ-043 halt=1 during a 16-bit read -> access completes with done; following req is ignored with halt_ack=1 until halt drops.
REQ-044 cen toggling 1-0-1 during an 8-bit read -> completion and done occur only on cen edges; outputs stable while cen=0.
